// File: rtl/display_frame_builder_pkg.sv
// Shared definitions for the display frame builder: FSM state encoding,
// segment constants and the BCD -> a..g segment lookup.
// Ports: none (package).
package display_frame_builder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ENCODE    = 2'd1,
    ST_LOAD      = 2'd2,
    ST_WAIT_BUSY = 2'd3
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         DP_BIT    = 7;

  // Bit order {g,f,e,d,c,b,a}. Codes 10-15 are not digits and show blank.
  function automatic logic [6:0] seg_lut(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK[6:0];
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_frame_builder_if.sv
// Bundle between the digit source / serial shifter and the frame builder.
// Ports: update_i, digits_i, dp_i, sr_idle_i (into builder); frame_o, start_o, busy_o (out of builder).
// master = the environment driving digits and the shifter flag; slave = the builder itself.
interface display_frame_builder_if #(
  parameter int DIGITS = 6
);
  logic                  update_i;
  logic [4*DIGITS-1:0]   digits_i;
  logic [DIGITS-1:0]     dp_i;
  logic                  sr_idle_i;
  logic [8*DIGITS-1:0]   frame_o;
  logic                  start_o;
  logic                  busy_o;

  modport master (
    output update_i, digits_i, dp_i, sr_idle_i,
    input  frame_o, start_o, busy_o
  );

  modport slave (
    input  update_i, digits_i, dp_i, sr_idle_i,
    output frame_o, start_o, busy_o
  );
endinterface

// File: rtl/display_frame_builder_seg7_encoder.sv
// Purpose: BCD digit plus decimal point -> one 7-segment byte {dp,g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd[3:0], dp in; seg[7:0] out.
module seg7_encoder
  import display_frame_builder_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg         = SEG_BLANK;
    seg[6:0]    = seg_lut(bcd);
    seg[DP_BIT] = dp;
  end

endmodule

// File: rtl/display_frame_builder.sv
// Purpose: snapshot DIGITS BCD digits + dps, encode one digit per cycle, launch one shifter transfer.
// Latency: update sampled at edge N -> frame_o/start_o valid after edge N+DIGITS+1 (shifter idle).
// Backpressure: waits in LOAD while sr_idle_i=0; updates while busy collapse into one pending redraw.
// Ports: clk_i, rst_i (async, active high), bus (display_frame_builder_if.slave).
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (rightmost digit always shown).
module display_frame_builder
  import display_frame_builder_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  display_frame_builder_if.slave  bus
);

  localparam int FW    = 8 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);
  localparam logic [FW-1:0]    FRAME_BLANK = {FW{SEG_ACTIVE_LOW}};

  state_e state_q, state_d;

  logic [4*DIGITS-1:0] digits_q;
  logic [DIGITS-1:0]   dp_q;
  logic [IDX_W-1:0]    idx_q;
  logic                pending_q;
  logic [FW-1:0]       shadow_q;
  logic [FW-1:0]       frame_q;
  logic                start_q;

  // FSM strobes
  logic take;
  logic enc_we;
  logic load;

  // Current digit being encoded
  logic [3:0] cur_bcd;
  logic       cur_dp;
  logic [7:0] enc_seg;
  logic [7:0] enc_byte;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    enc_we  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.update_i || pending_q) begin
          take    = 1'b1;
          state_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        enc_we = 1'b1;
        if (idx_q == '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Never touch the frame while the shifter is still reading it.
        if (bus.sr_idle_i) begin
          load    = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // The shifter drops its idle flag on the edge that sees start, so
        // this waits for that drop before allowing another launch.
        if (!bus.sr_idle_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_bcd = digits_q[4*int'(idx_q) +: 4];
    cur_dp  = dp_q[idx_q];
  end

  seg7_encoder u_enc (
    .bcd (cur_bcd),
    .dp  (cur_dp),
    .seg (enc_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic       leading_q;
  logic       blank_lead;
  logic [7:0] lead_byte;

  always_comb begin
    blank_lead        = leading_q && (cur_bcd == 4'd0) && (idx_q != '0);
    lead_byte         = SEG_BLANK;
    lead_byte[DP_BIT] = cur_dp;
    enc_byte          = blank_lead ? lead_byte : enc_seg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      leading_q <= 1'b0;
    end else if (take) begin
      leading_q <= 1'b1;
    end else if (enc_we && (cur_bcd != 4'd0)) begin
      leading_q <= 1'b0;
    end
  end
`else
  always_comb begin
    enc_byte = enc_seg;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digits_q  <= '0;
      dp_q      <= '0;
      idx_q     <= IDX_TOP;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      frame_q   <= FRAME_BLANK;
      start_q   <= 1'b0;
    end else begin
      if (take) begin
        digits_q  <= bus.digits_i;
        dp_q      <= bus.dp_i;
        idx_q     <= IDX_TOP;
        pending_q <= 1'b0;
      end else if (bus.update_i && (state_q != ST_IDLE)) begin
        // Snapshot stays untouched; redraw again with whatever is current
        // when the FSM next reaches IDLE.
        pending_q <= 1'b1;
      end

      if (enc_we) begin
        shadow_q[8*int'(idx_q) +: 8] <= enc_byte;
        if (idx_q != '0) idx_q <= idx_q - IDX_W'(1);
      end

      start_q <= load;
      if (load) frame_q <= SEG_ACTIVE_LOW ? ~shadow_q : shadow_q;
    end
  end

  assign bus.frame_o = frame_q;
  assign bus.start_o = start_q;
  assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_frame_builder.sv
// Randomised + directed bench for display_frame_builder with a small shifter model.
module tb_display_frame_builder;

  localparam int D  = 6;
  localparam int DW = 4 * D;
  localparam int FW = 8 * D;
  localparam bit AL = 1'b0;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  display_frame_builder_if #(.DIGITS(D)) bus ();

  display_frame_builder #(.DIGITS(D), .SEG_ACTIVE_LOW(AL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  logic [FW-1:0] exp_q[$];

  // Shifter model: drops idle on the edge it sees start, stays busy xfer_len cycles.
  logic sh_idle_q;
  int   sh_cnt;
  int   xfer_len = 8;
  logic hold = 1'b0;

  assign bus.sr_idle_i = sh_idle_q & ~hold;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_idle_q <= 1'b1;
      sh_cnt    <= 0;
    end else if (bus.start_o) begin
      sh_idle_q <= 1'b0;
      sh_cnt    <= xfer_len;
    end else if (sh_cnt != 0) begin
      sh_cnt <= sh_cnt - 1;
      if (sh_cnt == 1) sh_idle_q <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what the display should show for a given digit snapshot.
  function automatic logic [FW-1:0] model_frame(input logic [DW-1:0] dig, input logic [D-1:0] dp);
    logic [7:0]    pat [10];
    logic [FW-1:0] f;
    logic [7:0]    b;
    int            v;
`ifdef LEADING_ZERO_BLANK_EN
    bit            leading;
    leading = 1'b1;
`endif
    pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    f = '0;
    for (int i = D - 1; i >= 0; i--) begin
      v = int'(dig[4*i +: 4]);
      b = (v < 10) ? pat[v] : 8'h00;
`ifdef LEADING_ZERO_BLANK_EN
      if (leading && v == 0 && i != 0) b = 8'h00;
      if (v != 0) leading = 1'b0;
`endif
      if (dp[i]) b = b | 8'h80;
      f[8*i +: 8] = b;
    end
    return AL ? ~f : f;
  endfunction

  // Monitor: every launch must match the next expected frame, be one cycle
  // wide, and the frame must stay put while the shifter is busy.
  initial begin
    logic          prev_start;
    logic [FW-1:0] last_frame;
    prev_start = 1'b0;
    last_frame = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_start = 1'b0;
      end else begin
        if (bus.start_o) begin
          start_cnt++;
          if (prev_start) chk("start_width", {63'd0, prev_start}, 64'd0);
          if (exp_q.size() > 0) chk("frame", 64'(bus.frame_o), 64'(exp_q.pop_front()));
          else                  chk("spurious_start", 64'(bus.start_o), 64'd0);
          last_frame = bus.frame_o;
        end else if (!sh_idle_q) begin
          chk("frame_hold", 64'(bus.frame_o), 64'(last_frame));
        end
        prev_start = bus.start_o;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [D-1:0] p);
    @(negedge clk_i);
    bus.digits_i = d;
    bus.dp_i     = p;
    bus.update_i = 1'b1;
    @(negedge clk_i);
    bus.update_i = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (k < 300 && !bus.start_o) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, {63'd0, bus.start_o}, 64'd1);
  endtask

  task automatic wait_quiet(input int budget);
    int k;
    k = 0;
    while (k < budget && !(bus.busy_o == 1'b0 && bus.sr_idle_i && exp_q.size() == 0)) begin
      @(negedge clk_i);
      k++;
    end
    repeat (3) @(negedge clk_i);
    chk("quiet_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("quiet_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f0;
    logic [DW-1:0] d, de, last_d;
    logic [D-1:0]  p, pe, last_p;
    int s0, k, nz, ne;

    bus.update_i = 1'b0;
    bus.digits_i = '0;
    bus.dp_i     = '0;

    // Reset values, during and after reset
    repeat (3) @(negedge clk_i);
    chk("rst_frame", 64'(bus.frame_o), 64'({FW{AL}}));
    chk("rst_start", {63'd0, bus.start_o}, 64'd0);
    chk("rst_busy",  {63'd0, bus.busy_o},  64'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("post_rst_busy",  {63'd0, bus.busy_o},  64'd0);
    chk("post_rst_frame", 64'(bus.frame_o), 64'({FW{AL}}));

    // 1: basic redraw and latency
    exp_q.push_back(48'h065B4F666D7D);
    send(24'h123456, '0);
    k = 0;
    while (k < 30 && !bus.start_o) begin
      @(negedge clk_i);
      k++;
    end
    chk("t1_latency", 64'(k), 64'(D + 1));
    chk("t1_frame", 64'(bus.frame_o), 64'h065B4F666D7D);
    @(negedge clk_i);
    chk("t1_start_width", {63'd0, bus.start_o}, 64'd0);
    wait_quiet(500);

    // 2: shifter not idle -> LOAD stalls, frame untouched
    hold = 1'b1;
    f0 = bus.frame_o;
    s0 = start_cnt;
    exp_q.push_back(model_frame(24'h987654, 6'b100100));
    send(24'h987654, 6'b100100);
    repeat (100) @(negedge clk_i);
    chk("t2_no_start", 64'(start_cnt), 64'(s0));
    chk("t2_frame_kept", 64'(bus.frame_o), 64'(f0));
    chk("t2_busy", {63'd0, bus.busy_o}, 64'd1);
    hold = 1'b0;
    @(negedge clk_i);
    chk("t2_release_start", {63'd0, bus.start_o}, 64'd1);
    wait_quiet(500);

    // 3: several updates while busy collapse into one redraw with the last digits
    hold = 1'b1;
    s0 = start_cnt;
    exp_q.push_back(model_frame(24'h111111, '0));
    send(24'h111111, '0);
    send(24'h246802, 6'b000011);
    send(24'h135791, 6'b110000);
    send(24'h999999, '0);
    exp_q.push_back(48'h6F6F6F6F6F6F);
    hold = 1'b0;
    xfer_len = 30;
    wait_quiet(1000);
    chk("t3_start_count", 64'(start_cnt - s0), 64'd2);
    chk("t3_frame", 64'(bus.frame_o), 64'h6F6F6F6F6F6F);
    xfer_len = 8;

    // 4: non-decimal codes blank, dp still applied
    exp_q.push_back(48'h00003F065BCF);
    send(24'hAF0123, 6'b000001);
    wait_start("t4_start");
    chk("t4_byte5", 64'(bus.frame_o[47:40]), 64'h00);
    chk("t4_byte4", 64'(bus.frame_o[39:32]), 64'h00);
    chk("t4_dp0",   {63'd0, bus.frame_o[7]}, 64'd1);
    wait_quiet(500);

    // 5: leading zeros
`ifdef LEADING_ZERO_BLANK_EN
    exp_q.push_back(48'h00000000073F);
`else
    exp_q.push_back(48'h3F3F3F3F073F);
`endif
    send(24'h000070, '0);
    wait_start("t5_start");
    wait_quiet(500);

    // 6a: reset during ENCODE
    send(24'h888888, '1);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("t6a_start", {63'd0, bus.start_o}, 64'd0);
    chk("t6a_busy",  {63'd0, bus.busy_o},  64'd0);
    chk("t6a_frame", 64'(bus.frame_o), 64'({FW{AL}}));
    s0 = start_cnt;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("t6a_no_start", 64'(start_cnt), 64'(s0));

    // 6b: reset during WAIT_BUSY (start still high)
    exp_q.push_back(model_frame(24'h888888, '1));
    send(24'h888888, '1);
    wait_start("t6b_start");
    #1 rst_i = 1'b1;
    #1;
    chk("t6b_start", {63'd0, bus.start_o}, 64'd0);
    chk("t6b_busy",  {63'd0, bus.busy_o},  64'd0);
    chk("t6b_frame", 64'(bus.frame_o), 64'({FW{AL}}));
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_quiet(500);

    // Random: one redraw plus optional burst of updates while encoding
    for (int it = 0; it < 40; it++) begin
      xfer_len = $urandom_range(2, 20);
      d = DW'($urandom);
      p = D'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        nz = $urandom_range(1, D - 1);
        for (int j = D - 1; j >= D - nz; j--) d[4*j +: 4] = 4'd0;
      end
      ne = $urandom_range(0, 3);
      s0 = start_cnt;
      exp_q.push_back(model_frame(d, p));
      send(d, p);
      last_d = d;
      last_p = p;
      for (int e = 0; e < ne; e++) begin
        de = DW'($urandom);
        pe = D'($urandom);
        send(de, pe);
        last_d = de;
        last_p = pe;
      end
      if (ne > 0) exp_q.push_back(model_frame(last_d, last_p));
      wait_quiet(2000);
      chk("rand_start_count", 64'(start_cnt - s0), 64'((ne > 0) ? 2 : 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
